// File: rtl/rx_logic_if.sv
// AXI-Stream beat bundle between the receive deserialiser and the FIFO.
interface rx_logic_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;

  modport master (
    output tvalid, tdata, tkeep, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast,
    output tready
  );
endinterface

// File: rtl/rx_logic.sv
// Byte-serial link receiver packing bytes into 32-bit AXI-Stream beats.
// Define RX_PARITY_EN to expect an even-parity bit before the stop bit.
module rx_logic #(
  parameter int IDLE_TIMEOUT = 1000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic S_AXIS_Clk,
  input  logic S_AXIS_Rst,
  input  logic RXD,
  input  logic clk_1MHz_RX,
  output logic readyFlag_RX,
  rx_logic_if.master S_AXIS,
  output logic LED,
  output logic overflow_err,
`ifdef RX_PARITY_EN
  output logic parity_err,
`endif
  output logic frame_err
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
`ifdef RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_rxd_sync;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic                   r_clk_q;
  logic                   w_rxd;
  logic                   w_strobe;

  state_t      r_state, w_state_nx;
  logic [2:0]  r_bit_cnt, w_bit_nx;
  logic [7:0]  r_shift, w_shift_nx;
  logic        r_par_bad, w_par_bad_nx;
  logic        r_byte_valid, w_bv_nx;
  logic        w_ferr_set;
  logic        w_perr_set;

  logic [31:0] r_word;
  logic [3:0]  r_keep;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_pend;
  logic        r_pend_vld;
  logic [TW-1:0] r_idle_cnt;
  logic        w_timeout;

  logic        w_push;
  logic [31:0] w_push_data;
  logic [3:0]  w_push_keep;
  logic        w_push_last;

  logic        r_tvalid;
  logic [31:0] r_tdata;
  logic [3:0]  r_tkeep;
  logic        r_tlast;
  logic        r_ready;
  logic        r_led;
  logic        r_ovf;
  logic        r_ferr;
  logic        r_perr;
  logic        w_accept;

  assign w_rxd    = r_rxd_sync[SYNC_STAGES-1];
  assign w_strobe = r_clk_sync[SYNC_STAGES-1] & ~r_clk_q;

  always_ff @(posedge S_AXIS_Clk or posedge S_AXIS_Rst) begin
    if (S_AXIS_Rst) begin
      r_rxd_sync <= '1;
      r_clk_sync <= '0;
      r_clk_q    <= 1'b0;
    end else begin
      r_rxd_sync <= {r_rxd_sync[SYNC_STAGES-2:0], RXD};
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], clk_1MHz_RX};
      r_clk_q    <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge S_AXIS_Clk or posedge S_AXIS_Rst) begin
    if (S_AXIS_Rst) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_par_bad    <= 1'b0;
      r_byte_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_bit_cnt    <= w_bit_nx;
      r_shift      <= w_shift_nx;
      r_par_bad    <= w_par_bad_nx;
      r_byte_valid <= w_bv_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_bit_nx     = r_bit_cnt;
    w_shift_nx   = r_shift;
    w_par_bad_nx = r_par_bad;
    w_bv_nx      = 1'b0;
    w_ferr_set   = 1'b0;
    w_perr_set   = 1'b0;
    if (w_strobe) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_rxd) begin
            w_state_nx   = S_DATA;
            w_bit_nx     = 3'd0;
            w_par_bad_nx = 1'b0;
          end
        end
        S_DATA: begin
          w_shift_nx = {w_rxd, r_shift[7:1]};
          w_bit_nx   = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
`ifdef RX_PARITY_EN
            w_state_nx = S_PARITY;
`else
            w_state_nx = S_STOP;
`endif
          end
        end
`ifdef RX_PARITY_EN
        S_PARITY: begin
          w_par_bad_nx = ^{r_shift, w_rxd};
          w_state_nx   = S_STOP;
        end
`endif
        S_STOP: begin
          w_state_nx = S_IDLE;
          if (!w_rxd)
            w_ferr_set = 1'b1;
          else if (r_par_bad)
            w_perr_set = 1'b1;
          else
            w_bv_nx = 1'b1;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // A timeout only fires on the cycle the counter first reaches the limit.
  assign w_timeout = (r_idle_cnt == TW'(IDLE_TIMEOUT - 1)) && !r_byte_valid;

  always_comb begin
    w_push      = 1'b0;
    w_push_data = r_pend;
    w_push_keep = 4'hF;
    w_push_last = 1'b0;
    if (r_byte_valid) begin
      w_push = r_pend_vld;
    end else if (w_timeout && (r_pend_vld || r_byte_cnt != 2'd0)) begin
      w_push      = 1'b1;
      w_push_last = 1'b1;
      if (!r_pend_vld) begin
        w_push_data = r_word;
        w_push_keep = r_keep;
      end
    end
  end

  always_ff @(posedge S_AXIS_Clk or posedge S_AXIS_Rst) begin
    if (S_AXIS_Rst) begin
      r_word     <= 32'd0;
      r_keep     <= 4'd0;
      r_byte_cnt <= 2'd0;
      r_pend     <= 32'd0;
      r_pend_vld <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      if (r_byte_valid)
        r_idle_cnt <= '0;
      else if (r_idle_cnt != TW'(IDLE_TIMEOUT))
        r_idle_cnt <= r_idle_cnt + 1'b1;

      if (r_byte_valid) begin
        if (r_byte_cnt == 2'd3) begin
          r_pend     <= {r_shift, r_word[23:0]};
          r_pend_vld <= 1'b1;
          r_word     <= 32'd0;
          r_keep     <= 4'd0;
          r_byte_cnt <= 2'd0;
        end else begin
          r_word[{r_byte_cnt, 3'b000} +: 8] <= r_shift;
          r_keep[r_byte_cnt]               <= 1'b1;
          r_byte_cnt                       <= r_byte_cnt + 2'd1;
          r_pend_vld                       <= 1'b0;
        end
      end else if (w_push) begin
        r_pend_vld <= 1'b0;
        r_word     <= 32'd0;
        r_keep     <= 4'd0;
        r_byte_cnt <= 2'd0;
      end
    end
  end

  assign w_accept = r_tvalid & S_AXIS.tready;

  always_ff @(posedge S_AXIS_Clk or posedge S_AXIS_Rst) begin
    if (S_AXIS_Rst) begin
      r_tvalid <= 1'b0;
      r_tdata  <= 32'd0;
      r_tkeep  <= 4'd0;
      r_tlast  <= 1'b0;
      r_ready  <= 1'b1;
      r_led    <= 1'b1;
      r_ovf    <= 1'b0;
      r_ferr   <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      if (w_push && r_tvalid && !S_AXIS.tready) begin
        r_ovf <= 1'b1;
      end else if (w_push) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_push_data;
        r_tkeep  <= w_push_keep;
        r_tlast  <= w_push_last;
        r_ready  <= 1'b0;
      end else if (w_accept) begin
        r_tvalid <= 1'b0;
        r_ready  <= 1'b1;
      end

      if (r_byte_valid)
        r_led <= 1'b0;
      else if (w_accept && r_tlast)
        r_led <= 1'b1;

      if (w_ferr_set) r_ferr <= 1'b1;
      if (w_perr_set) r_perr <= 1'b1;
    end
  end

  assign S_AXIS.tvalid = r_tvalid;
  assign S_AXIS.tdata  = r_tdata;
  assign S_AXIS.tkeep  = r_tkeep;
  assign S_AXIS.tlast  = r_tlast;
  assign readyFlag_RX  = r_ready;
  assign LED           = r_led;
  assign overflow_err  = r_ovf;
  assign frame_err     = r_ferr;
`ifdef RX_PARITY_EN
  assign parity_err    = r_perr;
`else
  logic w_unused;
  assign w_unused = r_perr;
`endif

endmodule

// File: doc/rx_logic.md
Name: rx_logic

Overview:
- Receive-side counterpart of the byte-serial AXI-Stream transmit path.
- Deserialises framed bytes from the link pin RXD, sampled on rising edges of the link bit clock clk_1MHz_RX.
- Packs bytes little-endian into 32-bit AXI-Stream words with tkeep/tlast and drives a downstream AXI FIFO.
- Packet end is detected by an idle gap on the line; the transmit side inserts a gap of about 2000 clocks after each last beat.

Parameters:
- IDLE_TIMEOUT, 1000: S_AXIS_Clk cycles without a completed byte that close a packet. Must be less than the transmitter's post-packet gap.
- SYNC_STAGES, 2: flip-flop depth of the RXD and clk_1MHz_RX synchronisers (legal values 2 or 3).

Ports:
- S_AXIS_Clk  in  1  system clock.
- S_AXIS_Rst  in  1  asynchronous, active-high reset.
- RXD  in  1  serial data, idle high, asynchronous to S_AXIS_Clk.
- clk_1MHz_RX  in  1  link bit clock, asynchronous; its rising edge marks a sample point.
- readyFlag_RX  out  1  1 = output register empty (back-pressure indication to the far end).
- S_AXIS_tvalid  out  1  output word valid.
- S_AXIS_tready  in  1  downstream accept.
- S_AXIS_tdata  out  32  byte0 in [7:0] … byte3 in [31:24].
- S_AXIS_tkeep  out  4  byte lane valid mask, contiguous from bit 0.
- S_AXIS_tlast  out  1  last word of the packet.
- LED  out  1  0 = packet in progress, 1 = idle.
- overflow_err  out  1  sticky: a word was dropped.
- frame_err  out  1  sticky: a stop bit was sampled as 0.

Behaviour:
- Reset values:
  - tvalid, tlast, overflow_err, frame_err = 0.
  - tdata = 0, tkeep = 0.
  - LED = 1, readyFlag_RX = 1.
  - All FSMs idle, all counters 0.
  - Reset mid-frame discards all partial and pending data; no word is emitted.
- Synchronisation: RXD and clk_1MHz_RX pass through SYNC_STAGES flip-flops. One strobe fires when the synchronised clock shows a 0→1 transition; the bit FSM acts only on strobes.
- Bit FSM:
  - IDLE: strobe with RXD=0 → DATA, bit_cnt=0.
  - DATA: each strobe shifts RXD in LSB-first; after 8 bits → STOP.
  - STOP: on strobe with RXD=1, byte_valid pulses for 1 cycle → IDLE. With RXD=0, set frame_err, drop the byte → IDLE.
- Assembler:
  - byte_valid writes lane byte_cnt and sets keep[byte_cnt].
  - At byte_cnt=3 the word is complete: it moves to the pending register with keep 4'hF; byte_cnt returns to 0.
  - If the pending register is already full when a new byte_valid arrives, the pending word is pushed to the output first with tlast=0, in the same cycle.
- Idle timer:
  - Cleared on byte_valid; otherwise counts up, saturating at IDLE_TIMEOUT.
  - On reaching IDLE_TIMEOUT with data held (pending full or byte_cnt>0), push that data with tlast=1 and its tkeep (e.g. 4'b0011 for 2 bytes).
  - Pending and partial data cannot coexist at timeout, because the first byte of a new word always flushes pending.
- Output register:
  - A push loads tdata/tkeep/tlast and sets tvalid in the next cycle.
  - tvalid and all payload are held stable until tvalid&tready; tvalid clears in that cycle unless a push coincides (back-to-back allowed).
  - Push while tvalid=1 and tready=0: drop the new word, set overflow_err, keep the existing word.
- Latency: stop-bit strobe to byte_valid is 1 cycle. A timeout or next-word push reaches tvalid 1 cycle later.
- LED: cleared on the first byte_valid of a packet; set when a tlast word is accepted.
- readyFlag_RX = ~tvalid, registered.
- Simultaneous tready and push: accept and reload in the same cycle, with no bubble and no overflow.

Optional Feature:
- Macro RX_PARITY_EN.
- Defined:
  - An even-parity bit is expected between data bit 7 and the stop bit (state PARITY).
  - A mismatch drops the byte and sets a sticky output parity_err (1 bit, reset 0).
- Undefined: no PARITY state and no parity_err port; the frame is start + 8 data + stop.

Test Plan:
- Single byte 0x5A, then idle ≥ IDLE_TIMEOUT, tready=1 → one beat: tdata[7:0]=0x5A, tkeep=4'b0001, tlast=1; LED returns to 1.
- Bytes 0x11..0x18 back-to-back, tready=1 → beat 0x14131211 keep F tlast 0, then after timeout 0x18171615 keep F tlast 1.
- Five bytes 0xA0..0xA4 → beat 0xA3A2A1A0 keep F tlast 0, then 0x000000A4 keep 4'b0001 tlast 1.
- tready held 0 across three full words → first word held stable, overflow_err=1, readyFlag_RX=0; after tready=1, exactly that word is delivered.
- Stop bit forced to 0 on the second of 3 bytes → frame_err=1; word has tkeep=4'b0011 with bytes 1 and 3.
- Assert S_AXIS_Rst after 5 data bits → all outputs at reset values; the next clean byte 0x3C is received correctly.
